rr_arb_mux: RTL and testbench

RR_ARB_MUX -- requirements
Module: rr_arb_mux

---
 rtl/rr_arb_mux.sv | 116 +++++++++++
 tb/tb_rr_arb_mux.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// N-channel arbiter feeding a single-entry output register.
// Round-robin or fixed-priority grant; the winning beat is registered with its source index.
module rr_arb_mux #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int RR    = 1,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CH-1:0]       i_valid,
    input  logic [N_CH*WIDTH-1:0] i_data,
    output logic [N_CH-1:0]       o_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data,
    output logic [CW-1:0]         o_ch,
    input  logic                  i_ready
);

    // First requesting channel at or above start, wrapping past the top channel.
    function automatic logic [N_CH-1:0] first_from(input logic [N_CH-1:0] req,
                                                   input logic [CW-1:0]   start);
        logic [N_CH-1:0] gnt;
        logic            found;
        int              idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(start) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [CW-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (oh[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] g);
        logic [CW-1:0] nxt;
        if (int'(g) == N_CH - 1) nxt = '0;
        else                     nxt = g + CW'(1);
        return nxt;
    endfunction

    logic                o_valid_q, o_valid_d;
    logic [WIDTH-1:0]    o_data_q,  o_data_d;
    logic [CW-1:0]       o_ch_q,    o_ch_d;
    logic [CW-1:0]       ptr_q,     ptr_d;

    logic [CW-1:0]       start_idx;
    logic [N_CH-1:0]     grant;
    logic [N_CH-1:0]     ready;
    logic                load;
    logic                xfer;
    logic [CW-1:0]       g_idx;
    logic [WIDTH-1:0]    sel_data;

    always_comb begin
        // Fixed priority is round-robin with the search pinned to channel 0.
        start_idx = (RR != 0) ? ptr_q : '0;
        grant     = first_from(i_valid, start_idx);
        load      = !o_valid_q || i_ready;
        ready     = (i_rst_n && load) ? grant : '0;
        xfer      = |ready;
        g_idx     = onehot_to_idx(grant);

        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant[k]) sel_data = i_data[k*WIDTH +: WIDTH];
        end

        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_ch_d    = o_ch_q;
        ptr_d     = ptr_q;
        // A stalled register freezes everything, pointer included, so the grant is re-evaluated each cycle.
        if (load) begin
            o_valid_d = xfer;
            if (xfer) begin
                o_data_d = sel_data;
                o_ch_d   = g_idx;
                ptr_d    = (RR != 0) ? wrap_inc(g_idx) : ptr_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_ch_q    <= '0;
            ptr_q     <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_ch_q    <= o_ch_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o_ready = ready;
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_ch    = o_ch_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: round-robin, fixed-priority and 3-channel wrap instances.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A: RR=1, N_CH=4, WIDTH=8
    logic        a_rst_n, a_ird, a_ov;
    logic [3:0]  a_iv, a_ord;
    logic [31:0] a_id;
    logic [7:0]  a_od;
    logic [1:0]  a_och;

    // Instance B: RR=0, N_CH=4, WIDTH=8
    logic        b_rst_n, b_ird, b_ov;
    logic [3:0]  b_iv, b_ord;
    logic [31:0] b_id;
    logic [7:0]  b_od;
    logic [1:0]  b_och;

    // Instance C: RR=1, N_CH=3, WIDTH=16
    logic        c_rst_n, c_ird, c_ov;
    logic [2:0]  c_iv, c_ord;
    logic [47:0] c_id;
    logic [15:0] c_od;
    logic [1:0]  c_och;

    rr_arb_mux #(.WIDTH(8), .N_CH(4), .RR(1)) dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_valid(a_iv), .i_data(a_id),
        .o_ready(a_ord), .o_valid(a_ov), .o_data(a_od), .o_ch(a_och), .i_ready(a_ird)
    );

    rr_arb_mux #(.WIDTH(8), .N_CH(4), .RR(0)) dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_valid(b_iv), .i_data(b_id),
        .o_ready(b_ord), .o_valid(b_ov), .o_data(b_od), .o_ch(b_och), .i_ready(b_ird)
    );

    rr_arb_mux #(.WIDTH(16), .N_CH(3), .RR(1)) dut_c (
        .i_clk(clk), .i_rst_n(c_rst_n), .i_valid(c_iv), .i_data(c_id),
        .o_ready(c_ord), .o_valid(c_ov), .o_data(c_od), .o_ch(c_och), .i_ready(c_ird)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_rst_n = 1'b0; a_iv = 4'b1111; a_ird = 1'b1;
        a_id = {8'h13, 8'h12, 8'h11, 8'h10};
        b_rst_n = 1'b0; b_iv = 4'b0000; b_ird = 1'b1;
        b_id = {8'h23, 8'h22, 8'h21, 8'h20};
        c_rst_n = 1'b0; c_iv = 3'b000; c_ird = 1'b1;
        c_id = {16'hC002, 16'hC001, 16'hC000};

        // Reset state
        #1;
        check("a_ready_in_reset", 32'(a_ord), 32'h0);
        tick(); tick();
        check("a_valid_reset", 32'(a_ov), 32'h0);
        check("a_data_reset", 32'(a_od), 32'h0);
        check("a_ch_reset", 32'(a_och), 32'h0);
        check("c_valid_reset", 32'(c_ov), 32'h0);

        // Round-robin over all four channels, one beat per cycle
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("a_rr_ready_%0d", k), 32'(a_ord), 32'(4'b0001 << (k % 4)));
            tick();
            check($sformatf("a_rr_valid_%0d", k), 32'(a_ov), 32'h1);
            check($sformatf("a_rr_ch_%0d", k), 32'(a_och), 32'(k % 4));
            check($sformatf("a_rr_data_%0d", k), 32'(a_od), 32'(8'h10 + k % 4));
        end
        // Pointer now at 1; a lone request from channel 2 moves it to 3
        a_id[23:16] = 8'hA5;
        a_iv = 4'b0100;
        tick();
        check("a_hold_setup_ch", 32'(a_och), 32'h2);
        check("a_hold_setup_data", 32'(a_od), 32'hA5);

        // Stall: everything frozen for 5 cycles
        a_ird = 1'b0; a_iv = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("a_stall_ready_%0d", k), 32'(a_ord), 32'h0);
            tick();
            check($sformatf("a_stall_data_%0d", k), 32'(a_od), 32'hA5);
            check($sformatf("a_stall_ch_%0d", k), 32'(a_och), 32'h2);
            check($sformatf("a_stall_valid_%0d", k), 32'(a_ov), 32'h1);
        end
        a_ird = 1'b1;
        #1;
        check("a_unstall_ready", 32'(a_ord), 32'h8);
        tick();
        check("a_unstall_ch", 32'(a_och), 32'h3);
        check("a_unstall_data", 32'(a_od), 32'h13);

        // Single one-cycle request from channel 2 (pointer is 0)
        a_iv = 4'b0100;
        #1;
        check("a_single_ready", 32'(a_ord), 32'h4);
        tick();
        check("a_single_valid", 32'(a_ov), 32'h1);
        check("a_single_ch", 32'(a_och), 32'h2);
        a_iv = 4'b0000;
        #1;
        check("a_idle_ready", 32'(a_ord), 32'h0);
        tick();
        check("a_idle_valid", 32'(a_ov), 32'h0);
        check("a_idle_ch_hold", 32'(a_och), 32'h2);
        check("a_idle_data_hold", 32'(a_od), 32'hA5);
        a_iv = 4'b1111;
        #1;
        check("a_ptr3_ready", 32'(a_ord), 32'h8);
        tick();
        check("a_ptr3_ch", 32'(a_och), 32'h3);
        check("a_ptr3_valid", 32'(a_ov), 32'h1);

        // Mid-operation reset discards the held beat
        a_rst_n = 1'b0;
        #1;
        check("a_rst_ready", 32'(a_ord), 32'h0);
        tick();
        check("a_rst_valid", 32'(a_ov), 32'h0);
        check("a_rst_data", 32'(a_od), 32'h0);
        check("a_rst_ch", 32'(a_och), 32'h0);
        a_rst_n = 1'b1;
        #1;
        check("a_post_rst_ready", 32'(a_ord), 32'h1);
        tick();
        check("a_post_rst_ch", 32'(a_och), 32'h0);
        check("a_post_rst_data", 32'(a_od), 32'h10);

        // Fixed priority: channel 1 always beats channel 3
        b_iv = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("b_fp_ready_%0d", k), 32'(b_ord), 32'h2);
            tick();
            check($sformatf("b_fp_ch_%0d", k), 32'(b_och), 32'h1);
            check($sformatf("b_fp_data_%0d", k), 32'(b_od), 32'h21);
        end

        // Three-channel wrap: pointer to 2, then request {1,0} wraps to 0
        c_iv = 3'b010;
        #1;
        check("c_setup_ready", 32'(c_ord), 32'h2);
        tick();
        check("c_setup_ch", 32'(c_och), 32'h1);
        check("c_setup_data", 32'(c_od), 32'hC001);
        c_iv = 3'b011;
        #1;
        check("c_wrap_ready", 32'(c_ord), 32'h1);
        tick();
        check("c_wrap_ch", 32'(c_och), 32'h0);
        check("c_wrap_data", 32'(c_od), 32'hC000);
        #1;
        check("c_ptr1_ready", 32'(c_ord), 32'h2);
        tick();
        check("c_ptr1_ch", 32'(c_och), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
